// File: rtl/wblock_sum.sv
// rtl/wblock_sum.sv - block-sum accumulator over BLK_W x BLK_H pixel tiles of a raster stream
// Optional build macro WBLOCK_SUM_SAT_EN: saturate block sums at 2^SW-1 instead of wrapping.
module wblock_sum #(
  parameter int DW          = 8,
  parameter int BLK_W       = 2,
  parameter int BLK_H       = 2,
  parameter int LINE_BLOCKS = 4,
  parameter int SW          = 10,
  localparam int CW         = (LINE_BLOCKS > 1) ? $clog2(LINE_BLOCKS) : 1
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          hsync,
  input  logic          din_valid,
  input  logic [DW-1:0] din,
  output logic [SW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [CW-1:0] dout_col,
  output logic [7:0]    dout_row,
  output logic          overflow
);

  localparam int SXW = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam int BXW = $clog2(LINE_BLOCKS + 1);
  localparam int LYW = (BLK_H > 1) ? $clog2(BLK_H) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_LINE, ACTIVE} state_t;

  state_t           state_q;
  logic             vs_q, hs_q, first_q;
  logic [LYW-1:0]   ly_q;
  logic [7:0]       row_q;
  logic [SXW-1:0]   sx_q;
  logic [BXW-1:0]   bx_q;
  logic [SW:0]      acc_q [LINE_BLOCKS];
  logic [SW-1:0]    dout_q;
  logic             dval_q, ovf_q;
  logic [CW-1:0]    dcol_q;
  logic [7:0]       drow_q;

  logic             vs_rise, hs_rise, accept, blk_last, res_valid;
  logic [CW-1:0]    bidx;
  logic [SW:0]      sum_d;
  logic [SW-1:0]    res_d;

  always_comb begin
    vs_rise   = vsync & ~vs_q;
    hs_rise   = hsync & ~hs_q;
    bidx      = bx_q[CW-1:0];
    // Sync edges own their cycle; a pixel coinciding with one is not taken.
    accept    = din_valid && (state_q == ACTIVE) && !vs_rise && !hs_rise &&
                (bx_q < BXW'(LINE_BLOCKS));
    blk_last  = (sx_q == SXW'(BLK_W - 1)) && (ly_q == LYW'(BLK_H - 1));
    res_valid = accept && blk_last;
    sum_d     = acc_q[bidx] + (SW + 1)'(din);
`ifdef WBLOCK_SUM_SAT_EN
    res_d     = sum_d[SW] ? {SW{1'b1}} : sum_d[SW-1:0];
`else
    res_d     = sum_d[SW-1:0];
`endif
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
      first_q <= 1'b0;
      ly_q    <= '0;
      row_q   <= '0;
      sx_q    <= '0;
      bx_q    <= '0;
      for (int i = 0; i < LINE_BLOCKS; i++) acc_q[i] <= '0;
      dout_q  <= '0;
      dval_q  <= 1'b0;
      dcol_q  <= '0;
      drow_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      vs_q <= vsync;
      hs_q <= hsync;
      if (vs_rise) begin
        // A same-cycle hsync rise opens line 0 immediately.
        state_q <= hs_rise ? ACTIVE : WAIT_LINE;
        first_q <= !hs_rise;
        ly_q    <= '0;
        row_q   <= '0;
        sx_q    <= '0;
        bx_q    <= '0;
        for (int i = 0; i < LINE_BLOCKS; i++) acc_q[i] <= '0;
      end else if (hs_rise && state_q != IDLE) begin
        state_q <= ACTIVE;
        first_q <= 1'b0;
        sx_q    <= '0;
        bx_q    <= '0;
        if (!first_q) begin
          if (ly_q == LYW'(BLK_H - 1)) begin
            ly_q  <= '0;
            row_q <= row_q + 8'd1;
          end else begin
            ly_q <= ly_q + LYW'(1);
          end
        end
      end else if (accept) begin
        acc_q[bidx] <= blk_last ? '0 : sum_d;
        if (sx_q == SXW'(BLK_W - 1)) begin
          sx_q <= '0;
          bx_q <= bx_q + BXW'(1);
        end else begin
          sx_q <= sx_q + SXW'(1);
        end
      end

      // Single-entry output slot; a transfer this cycle frees it for a new result.
      if (res_valid) begin
        if (!dval_q || dout_ready) begin
          dout_q <= res_d;
          dcol_q <= bidx;
          drow_q <= row_q;
          dval_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (dval_q && dout_ready) begin
        dval_q <= 1'b0;
      end
      if (vs_rise) ovf_q <= 1'b0;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dval_q;
  assign dout_col   = dcol_q;
  assign dout_row   = drow_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_wblock_sum.sv
// tb/tb_wblock_sum.sv - scoreboard bench for wblock_sum (default build and an SW=9 instance)
module tb_wblock_sum;
  logic       pclk = 1'b0;
  logic       rst, vsync, hsync, din_valid, dout_ready;
  logic [7:0] din;
  logic [9:0] dout;
  logic       dout_valid, overflow;
  logic [1:0] dout_col;
  logic [7:0] dout_row;
  logic [8:0] dout9;
  logic       dout_valid9, overflow9;
  logic [1:0] dout_col9;
  logic [7:0] dout_row9;

  typedef struct {int v; int col; int row;} exp_t;
  exp_t exp_q[$];
  exp_t exp9_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  bit   mon9_en = 0;
  int   macc[4];

  wblock_sum u_dut (
    .pclk(pclk), .rst(rst), .vsync(vsync), .hsync(hsync), .din_valid(din_valid), .din(din),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_col(dout_col),
    .dout_row(dout_row), .overflow(overflow)
  );

  wblock_sum #(.SW(9)) u_dut9 (
    .pclk(pclk), .rst(rst), .vsync(vsync), .hsync(hsync), .din_valid(din_valid), .din(din),
    .dout(dout9), .dout_valid(dout_valid9), .dout_ready(dout_ready), .dout_col(dout_col9),
    .dout_row(dout_row9), .overflow(overflow9)
  );

  always #5 pclk = ~pclk;

  function automatic int fit(input int s, input int sw);
    int m;
    m = (1 << sw) - 1;
`ifdef WBLOCK_SUM_SAT_EN
    return (s > m) ? m : s;
`else
    return s & m;
`endif
  endfunction

  always @(negedge pclk) begin : mon
    exp_t e;
    if (mon_en && dout_valid && dout_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result dout=%0d col=%0d row=%0d, required no result", dout, dout_col, dout_row);
      end else begin
        e = exp_q.pop_front();
        if (dout !== 10'(e.v) || dout_col !== 2'(e.col) || dout_row !== 8'(e.row)) begin
          errors++;
          $display("FAIL result got dout=%0d col=%0d row=%0d, required dout=%0d col=%0d row=%0d",
                   dout, dout_col, dout_row, e.v, e.col, e.row);
        end
      end
    end
    if (mon9_en && dout_valid9 && dout_ready) begin
      checks++;
      if (exp9_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result_sw9 dout=%0d, required no result", dout9);
      end else begin
        e = exp9_q.pop_front();
        if (dout9 !== 9'(e.v) || dout_col9 !== 2'(e.col) || dout_row9 !== 8'(e.row)) begin
          errors++;
          $display("FAIL result_sw9 got dout=%0d col=%0d row=%0d, required dout=%0d col=%0d row=%0d",
                   dout9, dout_col9, dout_row9, e.v, e.col, e.row);
        end
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic pulse_hsync();
    hsync = 1'b1;
    tick();
    hsync = 1'b0;
  endtask

  task automatic drive_frame(input int nl, input int np, input bit gaps, input bit big, input bit same);
    int x, v;
    vsync = 1'b1;
    if (same) hsync = 1'b1;
    tick();
    vsync = 1'b0;
    hsync = 1'b0;
    tick();
    for (int b = 0; b < 4; b++) macc[b] = 0;
    for (int l = 0; l < nl; l++) begin
      if (!(same && l == 0)) pulse_hsync();
      x = 0;
      for (int p = 0; p < np; p++) begin
        if (gaps && (p % 3 == 2)) begin
          din_valid = 1'b0;
          tick();
        end
        v = big ? 255 : p + 1;
        din = 8'(v);
        din_valid = 1'b1;
        if (x < 8) begin
          macc[x / 2] += v;
          if ((x % 2 == 1) && (l % 2 == 1)) begin
            if (mon_en) exp_q.push_back('{fit(macc[x / 2], 10), x / 2, l / 2});
            if (mon9_en) exp9_q.push_back('{fit(macc[x / 2], 9), x / 2, l / 2});
            macc[x / 2] = 0;
          end
        end
        x++;
        tick();
      end
      din_valid = 1'b0;
      tick();
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50 && (exp_q.size() != 0 || exp9_q.size() != 0); i++) tick();
    checks++;
    if (exp_q.size() != 0 || exp9_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d/%0d, required 0", name, exp_q.size(), exp9_q.size());
      exp_q.delete();
      exp9_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vsync = 0; hsync = 0; din_valid = 0; din = 0; dout_ready = 1'b1;
    tick(); tick();
    checks++; if (dout !== 10'd0) begin errors++; $display("FAIL reset_dout got %0d required 0", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b required 0", dout_valid); end
    checks++; if (dout_col !== 2'd0) begin errors++; $display("FAIL reset_col got %0d required 0", dout_col); end
    checks++; if (dout_row !== 8'd0) begin errors++; $display("FAIL reset_row got %0d required 0", dout_row); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b required 0", overflow); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    mon_en = 1;
    drive_frame(2, 8, 0, 0, 0);
    wait_drain("basic");
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow got %0b required 0", overflow); end
  endtask

  task automatic test_rows();
    drive_frame(4, 8, 0, 0, 0);
    wait_drain("rows");
  endtask

  task automatic test_backpressure();
    mon_en = 0;
    dout_ready = 1'b0;
    drive_frame(2, 8, 0, 0, 0);
    repeat (3) tick();
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %0b required 1", dout_valid); end
    checks++; if (dout !== 10'd6) begin errors++; $display("FAIL bp_dout got %0d required 6", dout); end
    checks++; if (dout_col !== 2'd0) begin errors++; $display("FAIL bp_col got %0d required 0", dout_col); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow got %0b required 1", overflow); end
    vsync = 1'b1; tick(); vsync = 1'b0; tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow_clear got %0b required 0", overflow); end
    checks++; if (dout !== 10'd6) begin errors++; $display("FAIL bp_hold got %0d required 6", dout); end
    dout_ready = 1'b1;
    tick();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL bp_transfer got %0b required 0", dout_valid); end
    mon_en = 1;
  endtask

  task automatic test_wrap();
    mon9_en = 1;
    drive_frame(2, 8, 0, 1, 0);
    wait_drain("wrap");
    mon9_en = 0;
  endtask

  task automatic test_reset_midline();
    vsync = 1'b1; tick(); vsync = 1'b0; tick();
    pulse_hsync();
    for (int p = 0; p < 3; p++) begin
      din = 8'(p + 1); din_valid = 1'b1; tick();
    end
    din_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (dout !== 10'd0 || dout_valid !== 1'b0 || dout_col !== 2'd0 || dout_row !== 8'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL midline_reset got dout=%0d v=%0b col=%0d row=%0d ovf=%0b required all 0",
                        dout, dout_valid, dout_col, dout_row, overflow);
    end
    tick();
    rst = 1'b0;
    tick();
    for (int l = 0; l < 2; l++) begin
      pulse_hsync();
      for (int p = 0; p < 8; p++) begin
        din = 8'(p + 1); din_valid = 1'b1; tick();
      end
      din_valid = 1'b0;
      tick();
    end
    tick();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL idle_hsync got valid=%0b required 0", dout_valid); end
    drive_frame(2, 8, 0, 0, 0);
    wait_drain("after_reset");
  endtask

  task automatic test_gaps();
    drive_frame(2, 10, 1, 0, 0);
    wait_drain("gaps");
  endtask

  task automatic test_same_cycle();
    drive_frame(2, 8, 0, 0, 1);
    wait_drain("same_cycle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_rows();
    test_backpressure();
    test_wrap();
    test_reset_midline();
    test_gaps();
    test_same_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
